// File: rtl/mmu_loader.sv
// Byte-serial operand loader for the MMU feeder: collects 4 weights and 4 inputs from
// the host, then drives a 6-cycle RUN burst to the feeder.
module mmu_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [7:0] host_indata,
  input  logic       keep_weights,
  output logic [7:0] weight0,
  output logic [7:0] weight1,
  output logic [7:0] weight2,
  output logic [7:0] weight3,
  output logic [7:0] input0,
  output logic [7:0] input1,
  output logic [7:0] input2,
  output logic [7:0] input3,
  output logic       en,
  output logic [2:0] mmu_cycle,
  output logic       busy,
  output logic       overrun
);

  localparam logic [2:0] LastIdx  = 3'd7;
  localparam logic [2:0] LastStep = 3'd5;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic       en_q, en_d;
  logic [2:0] cyc_q, cyc_d;
  logic       ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    en_d    = en_q;
    cyc_d   = cyc_q;
    ovr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          state_d = StLoad;
          // Weight reuse skips straight to the input slots.
          if (keep_weights) begin
            regs_d[4] = host_indata;
            idx_d     = 3'd5;
          end else begin
            regs_d[0] = host_indata;
            idx_d     = 3'd1;
          end
        end
      end
      StLoad: begin
        if (load_valid) begin
          regs_d[idx_q] = host_indata;
          idx_d         = idx_q + 3'd1;
          if (idx_q == LastIdx) begin
            state_d = StRun;
            en_d    = 1'b1;
            cyc_d   = 3'd0;
          end
        end
      end
      StRun: begin
        ovr_d = load_valid;
        if (cyc_q == LastStep) begin
          state_d = StIdle;
          en_d    = 1'b0;
          cyc_d   = 3'd0;
          idx_d   = 3'd0;
        end else begin
          cyc_d = cyc_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      en_q    <= 1'b0;
      cyc_q   <= 3'd0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      cyc_q   <= cyc_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign weight0   = regs_q[0];
  assign weight1   = regs_q[1];
  assign weight2   = regs_q[2];
  assign weight3   = regs_q[3];
  assign input0    = regs_q[4];
  assign input1    = regs_q[5];
  assign input2    = regs_q[6];
  assign input3    = regs_q[7];
  assign en        = en_q;
  assign mmu_cycle = cyc_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_mmu_loader.sv
// Self-checking bench for mmu_loader: table-driven full load plus hand-written
// sequences for weight reuse, gaps, overrun, resets and back-to-back loads.
module tb_mmu_loader;

  logic       clk = 1'b0;
  logic       rst, load_valid, keep_weights;
  logic [7:0] host_indata;
  logic [7:0] weight0, weight1, weight2, weight3;
  logic [7:0] input0, input1, input2, input3;
  logic       en, busy, overrun;
  logic [2:0] mmu_cycle;

  mmu_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .host_indata (host_indata),
    .keep_weights(keep_weights),
    .weight0     (weight0),
    .weight1     (weight1),
    .weight2     (weight2),
    .weight3     (weight3),
    .input0      (input0),
    .input1      (input1),
    .input2      (input2),
    .input3      (input3),
    .en          (en),
    .mmu_cycle   (mmu_cycle),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] cyc;
    logic       busy;
    logic       ovr;
  } exp_t;

  typedef struct {
    logic       lv;
    logic [7:0] data;
    logic       kw;
    logic       en;
    logic [2:0] cyc;
    logic       busy;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[14];
  int   checks = 0;
  int   errors = 0;

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
  task automatic step(input string name, input logic r, input logic lv, input logic [7:0] d,
                      input logic kw, input logic e_en, input logic [2:0] e_cyc,
                      input logic e_busy, input logic e_ovr);
    exp_t e;
    exp_t want;
    rst          = r;
    load_valid   = lv;
    host_indata  = d;
    keep_weights = kw;
    e.en   = e_en;
    e.cyc  = e_cyc;
    e.busy = e_busy;
    e.ovr  = e_ovr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    checks++;
    if (en !== want.en || mmu_cycle !== want.cyc || busy !== want.busy ||
        overrun !== want.ovr) begin
      errors++;
      $display("FAIL %s: got en=%b cyc=%0d busy=%b ovr=%b, expected en=%b cyc=%0d busy=%b ovr=%b",
               name, en, mmu_cycle, busy, overrun, want.en, want.cyc, want.busy, want.ovr);
    end
  endtask

  task automatic check_regs(input string name, input logic [63:0] want);
    logic [63:0] got;
    got = {weight0, weight1, weight2, weight3, input0, input1, input2, input3};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got regs=%h, expected %h", name, got, want);
    end
  endtask

  // Remaining RUN cycles after the edge that entered RUN; optional overrun byte at ovr_at.
  task automatic run_phase(input string name, input int ovr_at);
    logic lv;
    for (int k = 1; k <= 5; k++) begin
      lv = ((k - 1) == ovr_at);
      step(name, 1'b0, lv, lv ? 8'hFF : 8'h00, 1'b0, 1'b1, 3'(k), 1'b1, lv);
    end
    step({name, "_end"}, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[5]  = '{1'b1, 8'h06, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[7]  = '{1'b1, 8'h08, 1'b0, 1'b1, 3'd0, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};

    rst = 1'b1; load_valid = 1'b0; host_indata = 8'h00; keep_weights = 1'b0;

    // Reset, including a byte offered during reset which must be ignored.
    step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step("reset_override", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_regs("reset_regs", 64'h0);
    step("idle_hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Full load from the vector table.
    for (int i = 0; i < 14; i++)
      step($sformatf("full_load_%0d", i), 1'b0, tbl[i].lv, tbl[i].data, tbl[i].kw,
           tbl[i].en, tbl[i].cyc, tbl[i].busy, 1'b0);
    check_regs("full_load_regs", 64'h01020304_05060708);

    // Weight reuse; keep_weights only on the first byte.
    for (int j = 0; j < 4; j++)
      step("reuse_load", 1'b0, 1'b1, 8'(8'h11 + j), (j == 0), (j == 3), 3'd0, 1'b1, 1'b0);
    run_phase("reuse_run", -1);
    check_regs("reuse_regs", 64'h01020304_11121314);

    // Gapped load from a cleared state, then overrun at mmu_cycle=2.
    step("reset2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_regs("reset2_regs", 64'h0);
    for (int b = 0; b < 8; b++) begin
      step("gap_byte", 1'b0, 1'b1, 8'(b + 1), 1'b0, (b == 7), 3'd0, 1'b1, 1'b0);
      if (b < 7)
        for (int g = 0; g < 3; g++)
          step("gap_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    end
    run_phase("overrun_run", 2);
    check_regs("overrun_regs", 64'h01020304_05060708);

    // Reset mid-LOAD, then a fresh full load.
    for (int j = 0; j < 5; j++)
      step("partial", 1'b0, 1'b1, 8'(8'h51 + j), 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    step("reset_mid_load", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++)
      step("reload", 1'b0, 1'b1, 8'(8'hA0 + j), 1'b0, (j == 7), 3'd0, 1'b1, 1'b0);
    run_phase("reload_run", -1);
    check_regs("reload_regs", 64'hA0A1A2A3_A4A5A6A7);

    // Back-to-back: first byte in the IDLE cycle right after RUN; keep_weights ignored later.
    step("b2b_first", 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_regs("b2b_first_regs", 64'hC0A1A2A3_A4A5A6A7);
    for (int j = 1; j < 8; j++)
      step("b2b_load", 1'b0, 1'b1, 8'(8'hC0 + j), 1'b1, (j == 7), 3'd0, 1'b1, 1'b0);
    run_phase("b2b_run", -1);
    check_regs("b2b_regs", 64'hC0C1C2C3_C4C5C6C7);

    // Reset mid-RUN aborts and clears.
    for (int j = 0; j < 4; j++)
      step("abort_load", 1'b0, 1'b1, 8'(8'hD0 + j), (j == 0), (j == 3), 3'd0, 1'b1, 1'b0);
    step("abort_run", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    step("reset_mid_run", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_regs("reset_mid_run_regs", 64'h0);
    step("post_reset_start", 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    check_regs("post_reset_regs", 64'h00000000_E0000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu_loader.md
MMU_LOADER -- requirements
Module: mmu_loader

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-003 load_valid  input  1  host byte strobe; one byte accepted per cycle while high.
REQ-004 host_indata  input  8  host data byte, qualified by load_valid.
REQ-005 keep_weights  input  1  sampled only with the first accepted byte of a sequence; 1 = bytes are inputs only, weights retained.
REQ-006 weight0..weight3  output  8 each  registered weight operands to the MMU feeder.
REQ-007 input0..input3  output  8 each  registered input operands to the MMU feeder.
REQ-008 en  output  1  registered enable to the feeder; high only in RUN.
REQ-009 mmu_cycle  output  3  registered feeder step count, 0..5.
REQ-010 busy  output  1  high in LOAD or RUN.
REQ-011 overrun  output  1  one-cycle registered pulse: byte offered while in RUN and dropped.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, LOAD, RUN.
REQ-013 Byte order SHALL be weight0, weight1, weight2, weight3, input0, input1, input2, input3, tracked by a 3-bit byte index.
REQ-014 In IDLE, load_valid=1 SHALL store the byte and enter LOAD: keep_weights=0 -> byte to weight0, next index 1; keep_weights=1 -> byte to input0, next index 5.
REQ-015 In LOAD, each load_valid=1 cycle SHALL write host_indata to the register at the current index, then increment it; load_valid=0 cycles hold all state (no timeout).
REQ-016 The byte written at index 7 (input3) SHALL move the FSM to RUN on the same edge, with mmu_cycle=0 and en=1 from the next cycle.
REQ-017 In RUN, mmu_cycle SHALL increment by 1 per cycle from 0 to 5; the edge leaving mmu_cycle=5 SHALL enter IDLE with en=0, mmu_cycle=0.
REQ-018 RUN SHALL last exactly 6 cycles with en=1; en SHALL be 0 in IDLE and LOAD.
REQ-019 Weight and input registers SHALL not change in RUN or IDLE; only LOAD/IDLE-entry writes modify them.
REQ-020 load_valid=1 in RUN SHALL drop the byte and pulse overrun for one cycle; no other state changes.
REQ-021 load_valid=1 in the IDLE cycle immediately after RUN SHALL be accepted as a new sequence start (back-to-back allowed).
REQ-022 keep_weights SHALL be ignored in LOAD and RUN.
REQ-023 busy SHALL equal (state != IDLE) registered with the state.
REQ-024 Latency: first byte to en=1 SHALL be 8 cycles (full load) or 4 cycles (keep_weights) with continuous load_valid.

Reset
REQ-025 rst=1 SHALL force state IDLE, byte index 0, en=0, mmu_cycle=0, busy=0, overrun=0, and all weight/input registers to 0, overriding any other input that cycle.
REQ-026 rst asserted mid-LOAD or mid-RUN SHALL abort the sequence; next accepted byte after rst deassertion SHALL be treated as a sequence start.

Verification
REQ-027 Full load: bytes 01..08 on consecutive cycles, keep_weights=0 -> weight0..3=01..04, input0..3=05..08, en high 6 cycles with mmu_cycle 0,1,2,3,4,5, then en=0.
REQ-028 Weight reuse: after REQ-027, bytes 11,12,13,14 with keep_weights=1 on first -> weights stay 01..04, inputs 11..14, RUN after 4th byte.
REQ-029 Gapped load: 8 bytes with load_valid idle 3 cycles between each -> same register result as REQ-027, busy high throughout, en stays 0 until 8th byte.
REQ-030 Overrun: load_valid=1 with data FF at mmu_cycle=2 -> overrun one-cycle pulse, registers unchanged, RUN completes normally.
REQ-031 Reset mid-LOAD: rst after 5 bytes, then 8 new bytes A0..A7 -> registers A0..A7, nothing from prior partial load.
REQ-032 Back-to-back: new byte offered the cycle after RUN ends -> accepted as weight0; mmu_cycle restarts at 0 in the next RUN.
